regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_W, 64, register width in bits.
REQ-002 Parameter: NREG, 32, number of architectural registers; address width is 5 bits, fixed.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 Port: wr_en  input  1  write strobe; a write is committed on the clk edge where wr_en=1.
REQ-006 Port: wr_reg  input  5  destination register index.
REQ-007 Port: wr_data  input  DATA_W  write data.
REQ-008 Port: rd_reg1  input  5  read port 1 index.
REQ-009 Port: rd_reg2  input  5  read port 2 index.
REQ-010 Port: rd_data1  output  DATA_W  read port 1 data.
REQ-011 Port: rd_data2  output  DATA_W  read port 2 data.
REQ-012 Port: wr_count  output  16  count of committed writes since reset.

Function
REQ-013 The storage SHALL be NREG registers of DATA_W bits, entries 0..30 writable, entry 31 hardwired to zero.
REQ-014 The write address SHALL be decoded 5-to-32 one-hot, gated by wr_en; exactly one register enable is active per committed write, none when wr_en=0.
REQ-015 On a rising clk edge with reset=0, wr_en=1 and wr_reg!=31, register wr_reg SHALL load wr_data; all other registers hold.
REQ-016 A write with wr_reg=31 SHALL be discarded; register 31 reads 0 in every cycle.
REQ-017 Read ports SHALL be combinational, zero-cycle latency: rd_dataN = register[rd_regN] as currently stored.
REQ-018 Both read ports SHALL operate independently; rd_reg1=rd_reg2 returns identical data on both.
REQ-019 wr_count SHALL increment by 1 on each edge with reset=0, wr_en=1 and wr_reg!=31; discarded writes do not count.
REQ-020 wr_count SHALL wrap 0xFFFF -> 0x0000 without saturating or flagging.
REQ-021 Without bypass, a read of wr_reg in the same cycle as its write SHALL return the old value; the new value is visible the cycle after the edge.

Reset
REQ-022 On a rising clk edge with reset=1, registers 0..30 SHALL clear to 0 and wr_count SHALL clear to 0.
REQ-023 reset SHALL take priority over wr_en on the same edge; the write is dropped and not counted.
REQ-024 Reset asserted mid-sequence SHALL discard no state other than registers and wr_count; the first write after deassertion commits normally on the next edge.
REQ-025 Outputs during and after reset SHALL read 0 on both ports for every index until written.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN: when defined, rd_dataN SHALL return wr_data combinationally when wr_en=1, reset=0, wr_reg=rd_regN and rd_regN!=31; otherwise stored data.
REQ-027 When REGFILE_BYPASS_EN is undefined, no forwarding path SHALL exist and REQ-021 applies.
REQ-028 Register 31 SHALL read 0 in both configurations, including when wr_reg=31 with wr_en=1.

Verification
REQ-029 Reset: assert reset 1 cycle, read all 32 indices on both ports -> all 0, wr_count=0.
REQ-030 Write/read: write reg i with value i*0x0101010101010101 for i=0..30, then read each on both ports -> exact values, wr_count=31.
REQ-031 Zero register: wr_en=1, wr_reg=31, wr_data=0xDEADBEEFDEADBEEF -> rd_data1 with rd_reg1=31 is 0 before and after the edge, wr_count unchanged.
REQ-032 Same-cycle hazard: reg 5=0x1, write reg 5=0x2 while rd_reg1=5 -> 0x1 before the edge without bypass, 0x2 with REGFILE_BYPASS_EN; 0x2 after the edge in both.
REQ-033 Reset priority: reset=1 and wr_en=1, wr_reg=3, wr_data=0xFF on the same edge -> reg 3 reads 0, wr_count=0.
REQ-034 Counter wrap: 65536 consecutive writes to reg 1 -> wr_count returns to 0x0000; one further write -> 0x0001.

Source files
------------

// File: rtl/regfile.sv
// 32-entry, two-read/one-write register file with a committed-write counter; entry 31 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned NREG   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4:0]        wr_reg,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_reg1,
   input  logic [4:0]        rd_reg2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [15:0]       wr_count
);

   localparam logic [4:0] ZERO_REG = 5'd31;

   // Entry 31 has no storage; only 0..NREG-2 are real registers.
   logic [DATA_W-1:0] regs_q [NREG-1];
   logic [NREG-2:0]   wr_sel;
   logic              wr_commit;
   logic [15:0]       wr_count_q, wr_count_d;

   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 0; i < NREG-1; i++) begin
         wr_sel[i] = wr_en && (wr_reg == 5'(i));
      end
   end

   assign wr_commit  = |wr_sel;
   assign wr_count_d = wr_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG-1; i++) begin
            regs_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG-1; i++) begin
            if (wr_sel[i]) regs_q[i] <= wr_data;
         end
         if (wr_commit) wr_count_q <= wr_count_d;
      end
   end

   assign wr_count = wr_count_q;

   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      if (rd_reg1 != ZERO_REG) rd_data1 = regs_q[rd_reg1];
      if (rd_reg2 != ZERO_REG) rd_data2 = regs_q[rd_reg2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && !reset && (wr_reg == rd_reg1) && (rd_reg1 != ZERO_REG)) rd_data1 = wr_data;
      if (wr_en && !reset && (wr_reg == rd_reg2) && (rd_reg2 != ZERO_REG)) rd_data2 = wr_data;
`endif
   end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expected values follow REGFILE_BYPASS_EN when defined.
module tb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [63:0] wr_data;
   logic [4:0]  rd_reg1, rd_reg2;
   logic [63:0] rd_data1, rd_data2;
   logic [15:0] wr_count;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   regfile #(.DATA_W(64), .NREG(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_reg   (wr_reg),
      .wr_data  (wr_data),
      .rd_reg1  (rd_reg1),
      .rd_reg2  (rd_reg2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_both(input logic [4:0] idx, input logic [63:0] exp, input string tag);
      rd_reg1 = idx;
      rd_reg2 = idx;
      #1;
      check($sformatf("%s_p1_r%0d", tag, idx), rd_data1, exp);
      check($sformatf("%s_p2_r%0d", tag, idx), rd_data2, exp);
   endtask

   logic [63:0] hazard_exp;
   logic [4:0]  idx;

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_data = '0; rd_reg1 = '0; rd_reg2 = '0;
`ifdef REGFILE_BYPASS_EN
      hazard_exp = 64'h2;
`else
      hazard_exp = 64'h1;
`endif

      // Reset: every index reads zero, counter zero
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         idx = 5'(i);
         read_both(idx, 64'h0, "rst");
      end
      check("rst_count", 64'(wr_count), 64'h0);

      // Write reg i with i*0x0101..01 for i=0..30
      for (int i = 0; i < 31; i++) begin
         wr_en = 1'b1;
         wr_reg = 5'(i);
         wr_data = 64'(i) * 64'h0101010101010101;
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         idx = 5'(i);
         read_both(idx, (i == 31) ? 64'h0 : 64'(i) * 64'h0101010101010101, "wr");
      end
      check("wr_count31", 64'(wr_count), 64'd31);

      // Idle edge: nothing changes
      tick();
      check("idle_count", 64'(wr_count), 64'd31);
      read_both(5'd17, 64'h1111111111111111, "idle");

      // Zero register discards writes
      rd_reg1 = 5'd31;
      wr_en = 1'b1; wr_reg = 5'd31; wr_data = 64'hDEADBEEFDEADBEEF;
      #1;
      check("z_before", rd_data1, 64'h0);
      tick();
      check("z_after", rd_data1, 64'h0);
      check("z_count", 64'(wr_count), 64'd31);
      wr_en = 1'b0;

      // Same-cycle hazard on reg 5
      wr_en = 1'b1; wr_reg = 5'd5; wr_data = 64'h1;
      tick();
      check("hz_count", 64'(wr_count), 64'd32);
      wr_data = 64'h2; rd_reg1 = 5'd5; rd_reg2 = 5'd5;
      #1;
      check("hz_before_p1", rd_data1, hazard_exp);
      check("hz_before_p2", rd_data2, hazard_exp);
      tick();
      wr_en = 1'b0;
      #1;
      check("hz_after", rd_data1, 64'h2);
      check("hz_count2", 64'(wr_count), 64'd33);

      // Reset beats a simultaneous write
      reset = 1'b1; wr_en = 1'b1; wr_reg = 5'd3; wr_data = 64'hFF;
      tick();
      reset = 1'b0; wr_en = 1'b0;
      read_both(5'd3, 64'h0, "rp");
      read_both(5'd5, 64'h0, "rp");
      check("rp_count", 64'(wr_count), 64'h0);

      // First write after deassertion commits normally
      wr_en = 1'b1; wr_reg = 5'd3; wr_data = 64'h77;
      tick();
      wr_en = 1'b0;
      read_both(5'd3, 64'h77, "post_rst");
      check("post_rst_count", 64'(wr_count), 64'd1);

      // Counter wrap over 65536 writes to reg 1
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr_en = 1'b1; wr_reg = 5'd1;
      for (int k = 0; k < 65535; k++) begin
         wr_data = 64'(k);
         tick();
      end
      check("wrap_ffff", 64'(wr_count), 64'hFFFF);
      wr_data = 64'd65535;
      tick();
      check("wrap_0000", 64'(wr_count), 64'h0);
      wr_en = 1'b0;
      read_both(5'd1, 64'd65535, "wrap_data");
      read_both(5'd2, 64'h0, "wrap_other");
      wr_en = 1'b1; wr_data = 64'hABC;
      tick();
      wr_en = 1'b0;
      check("wrap_0001", 64'(wr_count), 64'h1);
      read_both(5'd1, 64'hABC, "wrap_last");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
